// File: rtl/washmachine_phase_timer.sv
// Phase-duration timer for the washing-machine controller: times wash/water/dewater/alarm
// phases from the controller's Gray-coded state and returns level "time up" flags.
module washmachine_phase_timer #(
  parameter int TICK_DIV    = 50000000,
  parameter int CNT_W       = 8,
  parameter int WASH_SEC    = 30,
  parameter int WATER_SEC   = 10,
  parameter int DEWATER_SEC = 20,
  parameter int ALARM_SEC   = 5
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [2:0]       state_in,
  input  logic             pause,
  output logic             wash,
  output logic             water,
  output logic             dewater,
  output logic             alarm,
  output logic [CNT_W-1:0] sec_left,
  output logic             tick
);

  localparam int PS_W = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam logic [PS_W-1:0]  PS_MAX  = PS_W'(TICK_DIV - 1);
  localparam logic [PS_W-1:0]  PS_ONE  = PS_W'(1);
  localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

  localparam logic [2:0] ST_WASH    = 3'b011;
  localparam logic [2:0] ST_WATER   = 3'b010;
  localparam logic [2:0] ST_DEWATER = 3'b110;
  localparam logic [2:0] ST_ALARM   = 3'b100;

  localparam logic [CNT_W-1:0] D_WASH    = CNT_W'(WASH_SEC);
  localparam logic [CNT_W-1:0] D_WATER   = CNT_W'(WATER_SEC);
  localparam logic [CNT_W-1:0] D_DEWATER = CNT_W'(DEWATER_SEC);
  localparam logic [CNT_W-1:0] D_ALARM   = CNT_W'(ALARM_SEC);

  typedef enum logic [1:0] {
    S_IDLE,
    S_RUN,
    S_EXPIRED
  } tstate_t;

  tstate_t          r_fsm;
  logic [2:0]       r_state_q;
  logic [PS_W-1:0]  r_prescaler;
  logic [CNT_W-1:0] r_count;
  logic [3:0]       r_done;      // {alarm, dewater, water, wash}
  logic             r_tick;

  logic             w_change;
  logic             w_timed;
  logic [CNT_W-1:0] w_dur;
  logic [3:0]       w_entry_done;
  logic [3:0]       w_run_done;

  assign w_change = (state_in != r_state_q);

  always_comb begin
    w_timed      = 1'b1;
    w_dur        = '0;
    w_entry_done = 4'b0000;
    case (state_in)
      ST_WASH:    begin w_dur = D_WASH;    w_entry_done = 4'b0001; end
      ST_WATER:   begin w_dur = D_WATER;   w_entry_done = 4'b0010; end
      ST_DEWATER: begin w_dur = D_DEWATER; w_entry_done = 4'b0100; end
      ST_ALARM:   begin w_dur = D_ALARM;   w_entry_done = 4'b1000; end
      default:    w_timed = 1'b0;
    endcase
  end

  // While running with no change, the sampled state is the phase being timed.
  always_comb begin
    w_run_done = 4'b0000;
    case (r_state_q)
      ST_WASH:    w_run_done = 4'b0001;
      ST_WATER:   w_run_done = 4'b0010;
      ST_DEWATER: w_run_done = 4'b0100;
      ST_ALARM:   w_run_done = 4'b1000;
      default:    w_run_done = 4'b0000;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_fsm       <= S_IDLE;
      r_state_q   <= 3'b000;
      r_prescaler <= '0;
      r_count     <= '0;
      r_done      <= 4'b0000;
      r_tick      <= 1'b0;
    end else begin
      r_state_q <= state_in;
      r_tick    <= 1'b0;
      if (w_change) begin
        // A phase change outranks any tick or pause in the same cycle.
        r_prescaler <= '0;
        if (w_timed) begin
          r_count <= w_dur;
          if (w_dur == '0) begin
            r_fsm  <= S_EXPIRED;
            r_done <= w_entry_done;
          end else begin
            r_fsm  <= S_RUN;
            r_done <= 4'b0000;
          end
        end else begin
          r_fsm   <= S_IDLE;
          r_count <= '0;
          r_done  <= 4'b0000;
        end
      end else if (r_fsm == S_RUN && !pause) begin
        if (r_prescaler == PS_MAX) begin
          r_prescaler <= '0;
          r_tick      <= 1'b1;
          r_count     <= r_count - CNT_ONE;
          if (r_count == CNT_ONE) begin
            r_done <= w_run_done;
            r_fsm  <= S_EXPIRED;
          end
        end else begin
          r_prescaler <= r_prescaler + PS_ONE;
        end
      end
    end
  end

  assign wash     = r_done[0];
  assign water    = r_done[1];
  assign dewater  = r_done[2];
  assign alarm    = r_done[3];
  assign sec_left = r_count;
  assign tick     = r_tick;

endmodule

// File: tb/tb_washmachine_phase_timer.sv
// Scoreboarded bench for washmachine_phase_timer with TICK_DIV=4 and short phase durations.
module tb_washmachine_phase_timer;

  logic       clk;
  logic       reset;
  logic [2:0] state_in;
  logic       pause;
  logic       wash, water, dewater, alarm, tick;
  logic [7:0] sec_left;

  washmachine_phase_timer #(
    .TICK_DIV(4), .CNT_W(8), .WASH_SEC(3), .WATER_SEC(2), .DEWATER_SEC(0), .ALARM_SEC(1)
  ) dut (
    .clk(clk), .reset(reset), .state_in(state_in), .pause(pause),
    .wash(wash), .water(water), .dewater(dewater), .alarm(alarm),
    .sec_left(sec_left), .tick(tick)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    int          cyc;
    string       tag;
    logic [12:0] exp;
  } sb_t;

  sb_t sb_q[$];
  int  cyc = 0;
  int  n_tests = 0;
  int  n_fail = 0;
  int  e;

  always @(posedge clk) cyc <= cyc + 1;

  // obs = {tick, alarm, dewater, water, wash, sec_left}
  function automatic logic [12:0] mk(input bit t, input bit a, input bit d,
                                     input bit w, input bit s, input int sec);
    mk = {t, a, d, w, s, 8'(sec)};
  endfunction

  task automatic check_eq(input string tag, input logic [12:0] got, input logic [12:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got tick=%b al/dw/wt/ws=%b sec=%0d, want tick=%b al/dw/wt/ws=%b sec=%0d",
               tag, got[12], got[11:8], got[7:0], exp[12], exp[11:8], exp[7:0]);
    end
  endtask

  task automatic push(input int c, input string tag, input logic [12:0] v);
    sb_t s;
    s.cyc = c;
    s.tag = $sformatf("%s@%0d", tag, c);
    s.exp = v;
    sb_q.push_back(s);
  endtask

  task automatic wait_cyc(input int t);
    while (cyc < t) @(negedge clk);
  endtask

  always @(negedge clk) begin
    for (int i = sb_q.size() - 1; i >= 0; i--) begin
      if (sb_q[i].cyc == cyc) begin
        check_eq(sb_q[i].tag, {tick, alarm, dewater, water, wash, sec_left}, sb_q[i].exp);
        sb_q.delete(i);
      end
    end
  end

  initial begin
    reset = 1'b1; state_in = 3'b000; pause = 1'b0;
    push(1, "rst", mk(0,0,0,0,0,0));
    push(2, "rst", mk(0,0,0,0,0,0));
    wait_cyc(2); reset = 1'b0;

    // Nominal wash then water
    wait_cyc(3); state_in = 3'b011; e = 4;
    push(e,    "wash_load", mk(0,0,0,0,0,3));
    push(e+3,  "wash_hold", mk(0,0,0,0,0,3));
    push(e+4,  "wash_t1",   mk(1,0,0,0,0,2));
    push(e+5,  "tick_1cyc", mk(0,0,0,0,0,2));
    push(e+8,  "wash_t2",   mk(1,0,0,0,0,1));
    push(e+11, "wash_pre",  mk(0,0,0,0,0,1));
    push(e+12, "wash_up",   mk(1,0,0,0,1,0));
    push(e+16, "wash_held", mk(0,0,0,0,1,0));
    wait_cyc(e+16); state_in = 3'b010; e = e + 17;
    push(e,   "water_load", mk(0,0,0,0,0,2));
    push(e+4, "water_t1",   mk(1,0,0,0,0,1));

    // Stop abort mid-water, then re-entry
    wait_cyc(e+5); state_in = 3'b000; e = e + 6;
    for (int k = 0; k < 4; k++) push(e+k, "abort", mk(0,0,0,0,0,0));
    wait_cyc(e+3); state_in = 3'b010; e = e + 4;
    push(e,   "water_reload", mk(0,0,0,0,0,2));
    push(e+4, "water_t1b",    mk(1,0,0,0,0,1));
    push(e+8, "water_up",     mk(1,0,0,1,0,0));
    push(e+9, "water_held",   mk(0,0,0,1,0,0));

    // Zero-duration dewater, then alarm
    wait_cyc(e+9); state_in = 3'b110; e = e + 10;
    push(e,   "dew_zero", mk(0,0,1,0,0,0));
    push(e+2, "dew_held", mk(0,0,1,0,0,0));
    wait_cyc(e+2); state_in = 3'b100; e = e + 3;
    push(e,   "alarm_load", mk(0,0,0,0,0,1));
    push(e+3, "alarm_pre",  mk(0,0,0,0,0,1));
    push(e+4, "alarm_up",   mk(1,1,0,0,0,0));
    push(e+5, "alarm_held", mk(0,1,0,0,0,0));

    // Pause during wash
    wait_cyc(e+5); state_in = 3'b000; e = e + 6;
    push(e, "idle", mk(0,0,0,0,0,0));
    wait_cyc(e); state_in = 3'b011; e = e + 1;
    push(e, "wash_load2", mk(0,0,0,0,0,3));
    wait_cyc(e+1); pause = 1'b1;
    push(e+3, "paused",     mk(0,0,0,0,0,3));
    push(e+7, "paused_end", mk(0,0,0,0,0,3));
    wait_cyc(e+7); pause = 1'b0;
    push(e+9,  "resume_pre",   mk(0,0,0,0,0,3));
    push(e+10, "resume_t1",    mk(1,0,0,0,0,2));
    push(e+14, "resume_t2",    mk(1,0,0,0,0,1));
    push(e+17, "pause_pre_up", mk(0,0,0,0,0,1));
    push(e+18, "pause_up",     mk(1,0,0,0,1,0));
    wait_cyc(e+18); pause = 1'b1;
    push(e+19, "exp_pause", mk(0,0,0,0,1,0));
    push(e+20, "exp_pause", mk(0,0,0,0,1,0));
    wait_cyc(e+20); state_in = 3'b010; e = e + 21;
    push(e,   "load_paused", mk(0,0,0,0,0,2));
    push(e+4, "frozen",      mk(0,0,0,0,0,2));
    wait_cyc(e+4); pause = 1'b0;
    push(e+7, "unfreeze_pre",  mk(0,0,0,0,0,2));
    push(e+8, "unfreeze_tick", mk(1,0,0,0,0,1));

    // Reset mid-run
    wait_cyc(e+8); state_in = 3'b000; e = e + 9;
    push(e, "idle2", mk(0,0,0,0,0,0));
    wait_cyc(e); state_in = 3'b011; e = e + 1;
    push(e,   "wash_load3", mk(0,0,0,0,0,3));
    push(e+4, "wash3_t1",   mk(1,0,0,0,0,2));
    wait_cyc(e+4); reset = 1'b1;
    push(e+5, "rst_mid", mk(0,0,0,0,0,0));
    wait_cyc(e+5); reset = 1'b0; e = e + 6;
    push(e,   "reentry_rst", mk(0,0,0,0,0,3));
    push(e+4, "reentry_t1",  mk(1,0,0,0,0,2));
    push(e+8, "reentry_t2",  mk(1,0,0,0,0,1));

    // Phase change on the expiring tick edge
    wait_cyc(e+11); state_in = 3'b010; e = e + 12;
    push(e,   "collision",      mk(0,0,0,0,0,2));
    push(e+1, "collision_next", mk(0,0,0,0,0,2));

    // Unknown codes behave as idle
    wait_cyc(e+2); state_in = 3'b101; e = e + 3;
    push(e,   "unk101", mk(0,0,0,0,0,0));
    push(e+4, "unk101", mk(0,0,0,0,0,0));
    push(e+8, "unk101", mk(0,0,0,0,0,0));
    wait_cyc(e+8); state_in = 3'b111;
    push(e+9, "unk111", mk(0,0,0,0,0,0));

    wait_cyc(e+11);
    check_eq("sb_drain", 13'(sb_q.size()), 13'd0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/washmachine_phase_timer.md
Name: washmachine_phase_timer

Overview:
- Phase-duration scheduler for the washing-machine controller FSM.
- Watches the FSM's 3-bit state output and times the wash, water, dewater and alarm phases.
- Drives the level-active "time up" inputs (wash, water, dewater, alarm) back into the FSM.
- Exports the remaining seconds of the current phase for display.

Parameters:
- TICK_DIV, 50000000, clk cycles per 1-second tick (>=2)
- CNT_W, 8, width of the seconds counter
- WASH_SEC, 30, wash-phase duration in ticks
- WATER_SEC, 10, water-phase (drain) duration in ticks
- DEWATER_SEC, 20, dewater-phase duration in ticks
- ALARM_SEC, 5, alarm-phase duration in ticks

Ports:
- clk  in  1  system clock
- reset  in  1  synchronous reset, active-high
- state_in  in  3  controller state, Gray coded: 000 idle, 001 supply, 011 wash, 010 water, 110 dewater, 100 alarm
- pause  in  1  active-high; freezes prescaler and counter
- wash  out  1  wash time up, high while expired
- water  out  1  water time up, high while expired
- dewater  out  1  dewater time up, high while expired
- alarm  out  1  alarm time up, high while expired
- sec_left  out  CNT_W  remaining ticks of the current timed phase
- tick  out  1  one-cycle pulse per prescaler wrap while in RUN

Behaviour:
- Reset, synchronous, active-high:
  - State register goes to IDLE; prescaler, count and sec_left go to 0.
  - All done outputs and tick go to 0; the state_in history register goes to 000.
  - Reset dominates every other input.
- Internal registers: state_q (last sampled state_in), prescaler, count, timer FSM {IDLE, RUN, EXPIRED}.
- Phase-change detection:
  - Every edge, state_q <= state_in; a change is state_in != state_q.
  - Only one edge is needed; there is no debounce.
- Entry into a timed phase (state_in is 011, 010, 110 or 100, and differs from state_q) at edge E:
  - count <= the phase's duration; prescaler <= 0; all done outputs <= 0.
  - FSM goes to RUN, or to EXPIRED if the duration is 0.
  - A zero duration asserts that phase's done at edge E and needs no tick.
- Untimed or unknown state (000, 001, 101, 111):
  - FSM goes to IDLE; count <= 0; done outputs <= 0; no ticks.
- RUN, not paused:
  - The prescaler increments each cycle.
  - When prescaler == TICK_DIV-1 it wraps to 0, tick pulses, and count decrements.
  - The first decrement lands at edge E+TICK_DIV.
  - The decrement from 1 to 0 at edge E+N*TICK_DIV also sets the current phase's done output and moves the FSM to EXPIRED in that same edge.
- RUN, paused:
  - Prescaler, count and tick are held; tick = 0.
  - On release, counting resumes from the held prescaler value; the partial tick is not lost.
- EXPIRED:
  - Exactly one done output, the one mapped to the phase, stays high.
  - count = 0; no ticks; pause has no effect.
  - It is cleared at the edge that detects the next phase change. The controller FSM therefore sees the level for at least one cycle and consumes it.
- Simultaneous events:
  - A phase change in the same cycle as a tick: the phase change wins; the new count loads and the old phase's done never asserts.
  - A phase change in the same cycle as pause: the new phase loads and then stays frozen while pause remains high.
- Stop mid-phase (state_in returns to 000): the timer aborts, all outputs clear, and re-entry restarts the full duration.
- Re-entry of the same phase code with no intervening change is not a new entry.
- Width rules:
  - Durations are truncated to CNT_W bits; count never underflows below 0.
  - The prescaler is ceil(log2(TICK_DIV)) bits.
- sec_left = count, registered.
- At most one done output is ever high.

Test Plan (TICK_DIV=4, WASH_SEC=3, WATER_SEC=2, DEWATER_SEC=0, ALARM_SEC=1):
- Nominal wash: reset for 2 cycles; state_in=011 sampled at edge E. Required:
  - sec_left goes 3, 2, 1, 0 at edges E, E+4, E+8, E+12.
  - wash=1 from E+12 and held until state_in=010; it clears at the detecting edge while water=0 and sec_left=2.
- Pause: in wash, pause=1 for 6 cycles starting at E+2. Required:
  - No tick during the pause.
  - sec_left reaches 0 and wash rises at E+18.
- Stop abort: in water at sec_left=1, state_in=000. Required:
  - Next edge: sec_left=0 and water=0, and water never pulses.
  - Re-entering 010 reloads 2.
- Zero duration: state_in=110. Required:
  - dewater=1 at the entry edge and sec_left=0.
  - Then 100 gives alarm=1 exactly 4 cycles after entry, with dewater cleared at the entry edge.
- Reset mid-run: reset=1 at E+5 of wash. Required:
  - Next edge: all outputs 0, FSM in IDLE.
  - After release with state_in still 011, that counts as a new entry (state_q=000) and sec_left=3.
- Collision and unknown codes: a phase change on a tick edge loads the new duration with no done from the old phase; state_in=101 behaves as idle.
